vga_sprite_renderer: RTL and testbench

//  Pixel-colour stage directly downstream of the VGA sync/counter block.

---
 rtl/vga_pkg.sv | 14 +
 rtl/star_lfsr.sv | 21 ++
 rtl/vga_sprite_renderer.sv | 116 +++++++++++
 tb/tb_vga_sprite_renderer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, colour type and ship-position clamp
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int SHIP_W = 32;
    localparam int SHIP_H = 32;
    localparam logic [15:0] STAR_SEED = 16'hACE1;
    typedef logic [11:0] rgb444_t;
    localparam rgb444_t STAR_COLOR = 12'hCCC;
    localparam rgb444_t BG_COLOR = 12'h000;
    function automatic logic [9:0] clamp10(input logic [9:0] value, input logic [9:0] max);
        return (value > max) ? max : value;
    endfunction
endpackage

// File: rtl/star_lfsr.sv
// star_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) with seed reload
module star_lfsr #(
    parameter logic [15:0] SEED = vga_pkg::STAR_SEED
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    output logic [15:0] q
);
    logic [15:0] r_q;
    assign q = r_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_q <= SEED;
        else if (load)
            r_q <= SEED;
        else if (step)
            r_q <= {r_q[14:0], r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10]};
    end
endmodule

// File: rtl/vga_sprite_renderer.sv
// vga_sprite_renderer: 2-stage pixel colour pipeline drawing a starfield and a ship sprite
// whose position is handed over by valid/ready and committed only at frame start.
module vga_sprite_renderer
    import vga_pkg::rgb444_t, vga_pkg::clamp10, vga_pkg::STAR_COLOR, vga_pkg::BG_COLOR;
#(
    parameter int          H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int          V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter int          SHIP_W    = vga_pkg::SHIP_W,
    parameter int          SHIP_H    = vga_pkg::SHIP_H,
    parameter logic [15:0] STAR_SEED = vga_pkg::STAR_SEED
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       h_sync_i,
    input  logic       v_sync_i,
    input  logic       DE_i,
    input  logic [9:0] x_pixel,
    input  logic [9:0] y_pixel,
    input  logic       pos_valid,
    output logic       pos_ready,
    input  logic [9:0] ship_x,
    input  logic [9:0] ship_y,
    input  rgb444_t    ship_color,
    input  logic       ship_blink,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       h_sync_o,
    output logic       v_sync_o,
    output logic       DE_o,
    output logic       frame_start
);
    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - SHIP_W);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - SHIP_H);
    localparam logic [9:0] X_RST = 10'((H_ACTIVE - SHIP_W) / 2);
    localparam logic [9:0] Y_RST = 10'((V_ACTIVE - SHIP_H) / 2);

    logic [9:0]  r_ax, r_ay, r_sx, r_sy;
    logic        r_pending, r_prev_vs;
    logic [7:0]  r_frame_cnt;
    logic        r_s1_hs, r_s1_vs, r_s1_de, r_s1_fs, r_s1_ship, r_s1_star;
    logic        r_s2_hs, r_s2_vs, r_s2_de, r_s2_fs;
    rgb444_t     r_s2_rgb;
    logic [15:0] w_lfsr;
    logic        w_fs, w_accept, w_visible, w_in_ship, w_unused_lfsr;

    assign w_fs      = r_prev_vs & ~v_sync_i;
    assign w_accept  = pos_valid & ~r_pending;
    assign pos_ready = ~r_pending;
    assign w_visible = ~ship_blink | ~r_frame_cnt[3];
    // 11-bit compares keep ax+SHIP_W from wrapping at the right/bottom edge
    assign w_in_ship = ({1'b0, x_pixel} >= {1'b0, r_ax}) && ({1'b0, x_pixel} < {1'b0, r_ax} + 11'(SHIP_W))
                    && ({1'b0, y_pixel} >= {1'b0, r_ay}) && ({1'b0, y_pixel} < {1'b0, r_ay} + 11'(SHIP_H));
    assign w_unused_lfsr = ^w_lfsr[7:0];

    star_lfsr #(.SEED(STAR_SEED)) u_star_lfsr (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (w_fs),
        .step   (DE_i),
        .q      (w_lfsr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_vs   <= 1'b1;
            r_frame_cnt <= '0;
            r_pending   <= 1'b0;
            r_ax        <= X_RST;
            r_ay        <= Y_RST;
            r_sx        <= '0;
            r_sy        <= '0;
        end else begin
            r_prev_vs <= v_sync_i;
            if (w_fs)
                r_frame_cnt <= r_frame_cnt + 8'd1;
            if (w_fs && r_pending) begin
                r_ax      <= r_sx;
                r_ay      <= r_sy;
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_sx      <= clamp10(ship_x, X_MAX);
                r_sy      <= clamp10(ship_y, Y_MAX);
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {r_s1_hs, r_s1_vs, r_s2_hs, r_s2_vs} <= 4'b1111;
            {r_s1_de, r_s1_fs, r_s1_ship, r_s1_star, r_s2_de, r_s2_fs} <= '0;
            r_s2_rgb <= '0;
        end else begin
            r_s1_hs   <= h_sync_i;
            r_s1_vs   <= v_sync_i;
            r_s1_de   <= DE_i;
            r_s1_fs   <= w_fs;
            r_s1_ship <= w_in_ship & w_visible;
            r_s1_star <= &w_lfsr[15:8];
            r_s2_hs   <= r_s1_hs;
            r_s2_vs   <= r_s1_vs;
            r_s2_de   <= r_s1_de;
            r_s2_fs   <= r_s1_fs;
            r_s2_rgb  <= !r_s1_de ? BG_COLOR : r_s1_ship ? ship_color : r_s1_star ? STAR_COLOR : BG_COLOR;
        end
    end

    assign red         = r_s2_rgb[11:8];
    assign green       = r_s2_rgb[7:4];
    assign blue        = r_s2_rgb[3:0];
    assign h_sync_o    = r_s2_hs;
    assign v_sync_o    = r_s2_vs;
    assign DE_o        = r_s2_de;
    assign frame_start = r_s2_fs;
endmodule

// File: tb/tb_vga_sprite_renderer.sv
// tb_vga_sprite_renderer: directed scenario bench with a small LFSR/frame model for star pixels.
module tb_vga_sprite_renderer;
    logic        clk = 1'b0, reset_n = 1'b1;
    logic        h_sync_i = 1'b1, v_sync_i = 1'b1, DE_i = 1'b0;
    logic [9:0]  x_pixel = '0, y_pixel = '0, ship_x = '0, ship_y = '0;
    logic        pos_valid = 1'b0, ship_blink = 1'b0;
    logic [11:0] ship_color = 12'hF00;
    logic        pos_ready, h_sync_o, v_sync_o, DE_o, frame_start;
    logic [3:0]  red, green, blue;
    logic [11:0] rgb;
    int          n_checks = 0, n_errors = 0;
    logic [15:0] m_lfsr;
    logic        m_prev_vs, star_now;
    logic [7:0]  m_fc;

    assign rgb = {red, green, blue};

    vga_sprite_renderer dut (
        .clk(clk), .reset_n(reset_n), .h_sync_i(h_sync_i), .v_sync_i(v_sync_i), .DE_i(DE_i),
        .x_pixel(x_pixel), .y_pixel(y_pixel), .pos_valid(pos_valid), .pos_ready(pos_ready),
        .ship_x(ship_x), .ship_y(ship_y), .ship_color(ship_color), .ship_blink(ship_blink),
        .red(red), .green(green), .blue(blue), .h_sync_o(h_sync_o), .v_sync_o(v_sync_o),
        .DE_o(DE_o), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_prev_vs = 1'b1;
        m_fc = 8'd0;
    endtask

    // present one input cycle; star_now records whether that pixel should show a star
    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic de, input logic vs, input logic hs);
        x_pixel = x; y_pixel = y; DE_i = de; v_sync_i = vs; h_sync_i = hs;
        star_now = de && (m_lfsr[15:8] == 8'hFF);
        if (m_prev_vs && !vs) begin
            m_lfsr = 16'hACE1;
            m_fc = m_fc + 8'd1;
        end else if (de)
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_prev_vs = vs;
        step();
    endtask

    task automatic idle();
        drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic new_frame();
        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y, output logic [11:0] got, output logic [11:0] bg);
        drive(x, y, 1'b1, 1'b1, 1'b1);
        bg = star_now ? 12'hCCC : 12'h000;
        idle();
        got = rgb;
    endtask

    task automatic test_reset();
        logic s;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (rgb !== 12'h000) begin n_errors++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
        n_checks++; if (DE_o !== 1'b0) begin n_errors++; $display("FAIL reset_de got=%b exp=0", DE_o); end
        n_checks++; if ({h_sync_o, v_sync_o} !== 2'b11) begin n_errors++; $display("FAIL reset_syncs got=%b exp=11", {h_sync_o, v_sync_o}); end
        n_checks++; if (frame_start !== 1'b0) begin n_errors++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        n_checks++; if (pos_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%b exp=1", pos_ready); end
        step(); step();
        reset_n = 1'b1;
        drive(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
        s = star_now;
        idle();
        n_checks++; if ({DE_o, h_sync_o, v_sync_o} !== 3'b101) begin n_errors++; $display("FAIL idle_delay de/hs/vs got=%b exp=101", {DE_o, h_sync_o, v_sync_o}); end
        n_checks++; if (rgb !== (s ? 12'hCCC : 12'h000)) begin n_errors++; $display("FAIL idle_rgb got=%h exp=%h", rgb, s ? 12'hCCC : 12'h000); end
        idle();
        n_checks++; if ({DE_o, h_sync_o} !== 2'b01) begin n_errors++; $display("FAIL idle_after de/hs got=%b exp=01", {DE_o, h_sync_o}); end
        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        idle();
        n_checks++; if (v_sync_o !== 1'b0) begin n_errors++; $display("FAIL vsync_delay got=%b exp=0", v_sync_o); end
        drive(10'd304, 10'd224, 1'b0, 1'b1, 1'b1);
        idle();
        n_checks++; if (rgb !== 12'h000) begin n_errors++; $display("FAIL outside_de_rgb got=%h exp=000", rgb); end
    endtask

    task automatic test_default_ship();
        logic [11:0] got, bg;
        probe(10'd304, 10'd224, got, bg);
        n_checks++; if ({red, green, blue} !== 12'hF00) begin n_errors++; $display("FAIL ship_origin got=%h exp=F00", got); end
        probe(10'd335, 10'd255, got, bg);
        n_checks++; if (got !== 12'hF00) begin n_errors++; $display("FAIL ship_corner got=%h exp=F00", got); end
        probe(10'd336, 10'd224, got, bg);
        n_checks++; if (got !== bg) begin n_errors++; $display("FAIL ship_right_out got=%h exp=%h", got, bg); end
        probe(10'd303, 10'd224, got, bg);
        n_checks++; if (got !== bg) begin n_errors++; $display("FAIL ship_left_out got=%h exp=%h", got, bg); end
        probe(10'd304, 10'd256, got, bg);
        n_checks++; if (got !== bg) begin n_errors++; $display("FAIL ship_below_out got=%h exp=%h", got, bg); end
    endtask

    task automatic test_handshake();
        logic [11:0] got, bg;
        n_checks++; if (pos_ready !== 1'b1) begin n_errors++; $display("FAIL hs_ready_idle got=%b exp=1", pos_ready); end
        ship_x = 10'd100; ship_y = 10'd50; pos_valid = 1'b1;
        idle();
        pos_valid = 1'b0;
        n_checks++; if (pos_ready !== 1'b0) begin n_errors++; $display("FAIL hs_ready_pending got=%b exp=0", pos_ready); end
        probe(10'd304, 10'd224, got, bg);
        n_checks++; if (got !== 12'hF00) begin n_errors++; $display("FAIL hs_old_pos got=%h exp=F00", got); end
        probe(10'd100, 10'd50, got, bg);
        n_checks++; if (got !== bg) begin n_errors++; $display("FAIL hs_new_early got=%h exp=%h", got, bg); end
        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (pos_ready !== 1'b1) begin n_errors++; $display("FAIL hs_ready_after_commit got=%b exp=1", pos_ready); end
        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if ({frame_start, v_sync_o} !== 2'b10) begin n_errors++; $display("FAIL fs_pulse fs/vs got=%b exp=10", {frame_start, v_sync_o}); end
        drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (frame_start !== 1'b0) begin n_errors++; $display("FAIL fs_single got=%b exp=0", frame_start); end
        probe(10'd100, 10'd50, got, bg);
        n_checks++; if (got !== 12'hF00) begin n_errors++; $display("FAIL hs_new_pos got=%h exp=F00", got); end
        probe(10'd131, 10'd81, got, bg);
        n_checks++; if (got !== 12'hF00) begin n_errors++; $display("FAIL hs_new_corner got=%h exp=F00", got); end
        probe(10'd304, 10'd224, got, bg);
        n_checks++; if (got !== bg) begin n_errors++; $display("FAIL hs_old_gone got=%h exp=%h", got, bg); end
    endtask

    task automatic test_clamp_backpressure();
        logic [11:0] got, bg;
        ship_x = 10'd700; ship_y = 10'd470; pos_valid = 1'b1;
        idle();
        ship_x = 10'd10; ship_y = 10'd10;
        for (int i = 0; i < 4; i++) begin
            idle();
            n_checks++; if (pos_ready !== 1'b0) begin n_errors++; $display("FAIL bp_stall[%0d] got=%b exp=0", i, pos_ready); end
        end
        probe(10'd100, 10'd50, got, bg);
        n_checks++; if (got !== 12'hF00) begin n_errors++; $display("FAIL bp_old_pos got=%h exp=F00", got); end
        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (pos_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_commit got=%b exp=1", pos_ready); end
        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (pos_ready !== 1'b0) begin n_errors++; $display("FAIL bp_second_accept got=%b exp=0", pos_ready); end
        pos_valid = 1'b0;
        drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        probe(10'd608, 10'd448, got, bg);
        n_checks++; if (got !== 12'hF00) begin n_errors++; $display("FAIL clamp_origin got=%h exp=F00", got); end
        probe(10'd639, 10'd479, got, bg);
        n_checks++; if (got !== 12'hF00) begin n_errors++; $display("FAIL clamp_corner got=%h exp=F00", got); end
        probe(10'd607, 10'd448, got, bg);
        n_checks++; if (got !== bg) begin n_errors++; $display("FAIL clamp_left_out got=%h exp=%h", got, bg); end
        probe(10'd608, 10'd447, got, bg);
        n_checks++; if (got !== bg) begin n_errors++; $display("FAIL clamp_above_out got=%h exp=%h", got, bg); end
        new_frame();
        probe(10'd10, 10'd10, got, bg);
        n_checks++; if (got !== 12'hF00) begin n_errors++; $display("FAIL bp_second_pos got=%h exp=F00", got); end
        n_checks++; if (pos_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_final got=%b exp=1", pos_ready); end
    endtask

    task automatic test_blink();
        logic [11:0] got, bg, exp;
        ship_blink = 1'b1;
        for (int f = 0; f < 260; f++) begin
            new_frame();
            probe(10'd10, 10'd10, got, bg);
            exp = m_fc[3] ? bg : 12'hF00;
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL blink frame_cnt=%0d got=%h exp=%h", m_fc, got, exp); end
        end
        ship_blink = 1'b0;
    endtask

    task automatic test_stars();
        logic [11:0] prev_exp;
        logic        prev_de;
        logic [9:0]  y;
        for (int f = 0; f < 2; f++) begin
            new_frame();
            prev_exp = 12'h000;
            prev_de = 1'b0;
            for (int ln = 0; ln < 8; ln++) begin
                y = 10'(100 + ln);
                for (int x = 0; x < 656; x++) begin
                    if (x < 640)
                        drive(10'(x), y, 1'b1, 1'b1, 1'b1);
                    else
                        drive(10'd0, y, 1'b0, 1'b1, 1'b0);
                    n_checks++;
                    if (rgb !== prev_exp || DE_o !== prev_de) begin
                        n_errors++;
                        $display("FAIL star f=%0d y=%0d x=%0d rgb/de got=%h/%b exp=%h/%b", f, y, x - 1, rgb, DE_o, prev_exp, prev_de);
                    end
                    prev_exp = star_now ? 12'hCCC : 12'h000;
                    prev_de = (x < 640);
                end
            end
        end
    endtask

    task automatic test_reset_mid_line();
        logic [11:0] got, bg;
        ship_x = 10'd200; ship_y = 10'd200; pos_valid = 1'b1;
        idle();
        pos_valid = 1'b0;
        drive(10'd10, 10'd10, 1'b1, 1'b1, 1'b0);
        drive(10'd11, 10'd10, 1'b1, 1'b1, 1'b0);
        n_checks++; if ({rgb, h_sync_o, pos_ready} !== {12'hF00, 2'b00}) begin n_errors++; $display("FAIL pre_reset rgb/hs/rdy got=%h/%b/%b exp=F00/0/0", rgb, h_sync_o, pos_ready); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (rgb !== 12'h000) begin n_errors++; $display("FAIL midreset_rgb got=%h exp=000", rgb); end
        n_checks++; if ({h_sync_o, v_sync_o, DE_o} !== 3'b110) begin n_errors++; $display("FAIL midreset_sync hs/vs/de got=%b exp=110", {h_sync_o, v_sync_o, DE_o}); end
        n_checks++; if (pos_ready !== 1'b1) begin n_errors++; $display("FAIL midreset_ready got=%b exp=1", pos_ready); end
        x_pixel = '0; y_pixel = '0; DE_i = 1'b0; h_sync_i = 1'b1; v_sync_i = 1'b1;
        model_reset();
        step(); step();
        reset_n = 1'b1;
        new_frame();
        probe(10'd304, 10'd224, got, bg);
        n_checks++; if (got !== 12'hF00) begin n_errors++; $display("FAIL postreset_default got=%h exp=F00", got); end
        probe(10'd200, 10'd200, got, bg);
        n_checks++; if (got !== bg) begin n_errors++; $display("FAIL postreset_no_commit got=%h exp=%h", got, bg); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_ship();
        test_handshake();
        test_clamp_backpressure();
        test_blink();
        test_stars();
        test_reset_mid_line();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
